// File: rtl/menu_selector_pkg.sv
// Shared encodings for the menu selector: top-level state codes, menu tile
// codes and the unlock FSM state type.
package menu_selector_pkg;

   typedef enum logic [3:0] {
      MENU         = 4'd0,
      VOLUME       = 4'd1,
      POKEMON      = 4'd2,
      POKEMON_OVER = 4'd3,
      FRUIT        = 4'd4,
      POTION       = 4'd5,
      POTION_INIT  = 4'd6,
      POTION_WIN   = 4'd7
   } top_state_e;

   // {row,col}
   typedef enum logic [1:0] {
      TILE_VOLUME  = 2'b00,
      TILE_POKEMON = 2'b01,
      TILE_FRUIT   = 2'b10,
      TILE_POTION  = 2'b11
   } tile_e;

   typedef enum logic {
      LOCK_HELD = 1'b0,
      LOCK_OPEN = 1'b1
   } lock_e;

   localparam int IDLE_W = 14;

endpackage

// File: rtl/menu_selector_if.sv
// Button / state / cursor bundle between the top-level game FSM and the menu
// selector. The freq signal exists only when MENU_LOCK_EN is defined.
interface menu_selector_if;

   logic       btnC;
   logic       btnL;
   logic       btnR;
   logic       btnU;
   logic       btnD;
   logic [3:0] state;
`ifdef MENU_LOCK_EN
   logic [11:0] freq;
`endif
   logic [1:0] nextStateMenu;
   logic       locked;
   logic       menu_active;

`ifdef MENU_LOCK_EN
   modport master (
      output btnC, btnL, btnR, btnU, btnD, state, freq,
      input  nextStateMenu, locked, menu_active
   );
   modport slave (
      input  btnC, btnL, btnR, btnU, btnD, state, freq,
      output nextStateMenu, locked, menu_active
   );
`else
   modport master (
      output btnC, btnL, btnR, btnU, btnD, state,
      input  nextStateMenu, locked, menu_active
   );
   modport slave (
      input  btnC, btnL, btnR, btnU, btnD, state,
      output nextStateMenu, locked, menu_active
   );
`endif

endinterface

// File: rtl/menu_selector_freq_unlock.sv
// Microphone-frequency unlock: the menu opens after UNLOCK_CYCLES consecutive
// cycles with FREQ_LO <= freq <= FREQ_HI, and stays open until reset.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   LOCK_HELD | counting consecutive in-band cycles, menu still locked
//   LOCK_OPEN | unlock achieved, sticky until reset
module freq_unlock
   import menu_selector_pkg::*;
#(
   parameter int UNLOCK_CYCLES = 2000,
   parameter int FREQ_LO       = 200,
   parameter int FREQ_HI       = 700
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] freq,
   output logic        unlocked
);

   localparam int            CW   = $clog2(UNLOCK_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(UNLOCK_CYCLES - 1);
   localparam logic [11:0]   LO   = 12'(FREQ_LO);
   localparam logic [11:0]   HI   = 12'(FREQ_HI);

   lock_e         st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_band;

   assign in_band  = (freq >= LO) && (freq <= HI);
   assign unlocked = (st_q == LOCK_OPEN);

   // State and run-length counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q  <= LOCK_HELD;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   // The unlocking cycle must itself be in band: it is the UNLOCK_CYCLES-th
   // consecutive one, so a dropout right after LAST still re-locks the count.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
         LOCK_HELD: begin
            if (!in_band) begin
               cnt_d = '0;
            end else if (cnt_q == LAST) begin
               st_d  = LOCK_OPEN;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LOCK_OPEN: cnt_d = '0;
         default: begin
            st_d  = LOCK_HELD;
            cnt_d = '0;
         end
      endcase
   end

endmodule

// File: rtl/menu_selector.sv
// Menu cursor for the 2x2 game-select grid with idle return-to-home.
// Build option: define MENU_LOCK_EN to gate the menu behind a frequency unlock
// (adds the freq signal and freq_unlock); undefined, locked is tied low.
module menu_selector
   import menu_selector_pkg::*;
#(
   parameter int IDLE_TIMEOUT  = 10000,
   parameter int UNLOCK_CYCLES = 2000,
   parameter int FREQ_LO       = 200,
   parameter int FREQ_HI       = 700
) (
   input  logic            clk,
   input  logic            reset,
   menu_selector_if.slave  bus
);

   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

   if (FREQ_LO > FREQ_HI || UNLOCK_CYCLES < 1 ||
       IDLE_TIMEOUT < 1 || IDLE_TIMEOUT >= (1 << IDLE_W)) begin : g_bad_cfg
      $error("menu_selector: inconsistent parameter set");
   end

   logic [1:0]        tile_q, tile_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              active_q, active_d;
   logic              unlocked;
   logic              any_btn;

`ifdef MENU_LOCK_EN
   freq_unlock #(
      .UNLOCK_CYCLES (UNLOCK_CYCLES),
      .FREQ_LO       (FREQ_LO),
      .FREQ_HI       (FREQ_HI)
   ) u_unlock (
      .clk      (clk),
      .reset    (reset),
      .freq     (bus.freq),
      .unlocked (unlocked)
   );
`else
   assign unlocked = 1'b1;
`endif

   assign any_btn           = bus.btnC | bus.btnL | bus.btnR | bus.btnU | bus.btnD;
   assign bus.nextStateMenu = tile_q;
   assign bus.menu_active   = active_q;
   assign bus.locked        = ~unlocked;

   // Cursor, idle timer and menu-active registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tile_q   <= TILE_VOLUME;
         idle_q   <= '0;
         active_q <= 1'b0;
      end else begin
         tile_q   <= tile_d;
         idle_q   <= idle_d;
         active_q <= active_d;
      end
   end

   // Moves act on the registered menu_active; btnC freezes the cursor so the
   // consumer sees a stable tile in the select cycle. Leaving MENU just stops
   // accepting moves, so the last tile is remembered.
   always_comb begin
      tile_d   = tile_q;
      idle_d   = idle_q;
      active_d = (bus.state == MENU) && unlocked;

      if (!active_q || any_btn) begin
         idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
         idle_d = '0;
         tile_d = TILE_VOLUME;
      end else if (idle_q != '1) begin
         idle_d = idle_q + IDLE_W'(1);
      end

      if (active_q && !bus.btnC) begin
         if (bus.btnU || bus.btnD) begin
            tile_d = {~tile_q[1], tile_q[0]};
         end else if (bus.btnL || bus.btnR) begin
            tile_d = {tile_q[1], ~tile_q[0]};
         end
      end
   end

endmodule
